// File: rtl/codec_fifo.sv
`default_nettype none
// ============================================================================
// Module   : codec_fifo
// Purpose  : Elastic sample buffer between an echo stage and an audio codec.
//            A circular store of 2^DEPTH_LOG2 signed 16-bit samples with a
//            FILL/RUN controller. Output starts only after PREFILL samples
//            have been collected. An underrun drops the controller back to
//            FILL so the buffer can rebuild its cushion.
// Ports    : clk          - system clock, rising-edge active
//            reset        - synchronous active-high reset
//            sample_in    - signed sample from the echo stage
//            in_ready     - one-cycle strobe qualifying sample_in
//            codec_ready  - one-cycle strobe requesting the next sample
//            clear_flags  - synchronous clear of the sticky status flags
//            sample_out   - registered sample presented to the codec
//            level        - number of stored entries (0 .. 2^DEPTH_LOG2)
//            filling      - high while the controller is in FILL
//            overflow     - sticky: a sample was dropped because the store was full
//            underflow    - sticky: the codec asked for a sample while empty in RUN
// Config   : CODEC_FIFO_STATUS_EN - when defined, overflow/underflow are live
//            sticky flags. When undefined, both are tied to 0 and clear_flags
//            is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module codec_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           sample_in,
    input  logic                  in_ready,
    input  logic                  codec_ready,
    input  logic                  clear_flags,
    output logic [15:0]           sample_out,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  filling,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [15:0]             r_mem [DEPTH];

    logic                    w_full;
    logic                    w_empty;
    logic                    w_rd_en;
    logic                    w_wr_en;
    logic                    w_ovf_evt;
    logic                    w_udf_evt;
    logic [DEPTH_LOG2:0]     w_level_nxt;

    // ------------------------------------------------------------------------
    // Access decisions. The read decision uses only the current level, so a
    // write arriving while full can be accepted when a read frees a slot in
    // the same cycle. There is no bypass: a read at level 0 is always an
    // underrun even if a write lands in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_full      = (level == DEPTH_LVL);
        w_empty     = (level == '0);
        w_rd_en     = (r_state == ST_RUN) && codec_ready && !w_empty;
        w_udf_evt   = (r_state == ST_RUN) && codec_ready &&  w_empty;
        w_wr_en     = in_ready && (!w_full || w_rd_en);
        w_ovf_evt   = in_ready &&  w_full && !w_rd_en;

        w_level_nxt = level;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_level_nxt = level + 1'b1;
            2'b01:   w_level_nxt = level - 1'b1;
            default: w_level_nxt = level;
        endcase

        // FILL leaves as soon as the post-edge level meets the prefill mark.
        // RUN falls back to FILL on an underrun.
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_level_nxt >= PREFILL_LVL) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_udf_evt)                  w_state_nxt = ST_FILL;
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage array. Contents are not reset; stale data is never visible
    // because level gates every read.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, level, controller state and registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            level      <= '0;
            sample_out <= '0;
            r_state    <= ST_FILL;
            filling    <= 1'b1;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            level   <= w_level_nxt;
            r_state <= w_state_nxt;
            // Decoded from the next state so filling tracks r_state exactly.
            filling <= (w_state_nxt == ST_FILL);

            // While filling, the codec is fed silence. An underrun in RUN
            // leaves the previous sample in place.
            if (codec_ready) begin
                if (r_state == ST_FILL) begin
                    sample_out <= '0;
                end else if (w_rd_en) begin
                    sample_out <= r_mem[r_rd_ptr];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky status flags. A set event in the same cycle as clear_flags wins.
    // ------------------------------------------------------------------------
`ifdef CODEC_FIFO_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clear_flags) || w_ovf_evt;
            underflow <= (underflow && !clear_flags) || w_udf_evt;
        end
    end
`else
    logic w_unused_status;
    assign w_unused_status = clear_flags | w_ovf_evt;
    assign overflow        = 1'b0;
    assign underflow       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/codec_fifo.md
CODEC_FIFO -- requirements
Module: codec_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving log2 of the storage depth (16 entries).
REQ-002 SHALL have parameter PREFILL, default 8, giving the level at which output starts (1 to 2^DEPTH_LOG2).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sample_in, input, 16 bits: signed sample from the echo stage.
REQ-006 SHALL have port in_ready, input, 1 bit: one-cycle pulse marking sample_in valid.
REQ-007 SHALL have port codec_ready, input, 1 bit: one-cycle pulse requesting the next sample.
REQ-008 SHALL have port sample_out, output, 16 bits: signed sample presented to the codec, registered.
REQ-009 SHALL have port level, output, DEPTH_LOG2+1 bits: current number of stored entries.
REQ-010 SHALL have port filling, output, 1 bit: high while in state FILL.
REQ-011 SHALL have port overflow, output, 1 bit: sticky status flag (see Configuration).
REQ-012 SHALL have port underflow, output, 1 bit: sticky status flag (see Configuration).
REQ-013 SHALL have port clear_flags, input, 1 bit: synchronous clear of both sticky flags.

Function
REQ-014 SHALL be a circular buffer of 2^DEPTH_LOG2 x 16-bit entries, with read and write pointers wrapping modulo the depth.
REQ-015 SHALL write sample_in and advance the write pointer on in_ready when not full.
REQ-016 SHALL drop the sample on in_ready when full (level = depth) and leave the pointers unchanged; it SHALL set overflow.
REQ-017 SHALL implement state machine FILL/RUN; reset enters FILL.
REQ-018 In FILL, codec_ready SHALL load sample_out with 0, pop nothing, and SHALL NOT set underflow.
REQ-019 In FILL, the FSM SHALL move to RUN on the edge where the updated level reaches at least PREFILL.
REQ-020 In RUN, codec_ready with level > 0 SHALL load sample_out with the oldest entry and advance the read pointer.
REQ-021 sample_out SHALL be valid on the cycle after codec_ready (1-cycle latency).
REQ-022 In RUN, codec_ready with level = 0 SHALL hold sample_out, pop nothing, set underflow, and return the FSM to FILL.
REQ-023 sample_out SHALL hold its value between codec_ready pulses.
REQ-024 On simultaneous in_ready and codec_ready in RUN with 0 < level < depth, the block SHALL both write and read, leaving level unchanged.
REQ-025 On simultaneous in_ready and codec_ready when full in RUN, the block SHALL read and write, leaving level unchanged, and SHALL NOT set overflow.
REQ-026 On simultaneous in_ready and codec_ready when empty in RUN, the write SHALL occur, the read SHALL be treated as underflow (no bypass), and level SHALL become 1.
REQ-027 level SHALL update on the same edge as the write or read it reflects.
REQ-028 filling SHALL be a registered decode of the FSM state.

Reset
REQ-029 While reset is high: pointers = 0, level = 0, sample_out = 0, state = FILL, filling = 1, overflow = 0, underflow = 0; storage contents are don't-care.
REQ-030 reset SHALL dominate in_ready, codec_ready and clear_flags in the same cycle.
REQ-031 Asserting reset mid-stream SHALL discard all stored samples.

Configuration
REQ-032 SHALL use macro CODEC_FIFO_STATUS_EN.
REQ-033 With CODEC_FIFO_STATUS_EN defined, overflow and underflow SHALL be sticky and set as specified above.
REQ-034 With CODEC_FIFO_STATUS_EN defined, clear_flags SHALL zero both flags on the next edge; a set event in the same cycle SHALL win over the clear.
REQ-035 Without CODEC_FIFO_STATUS_EN, overflow and underflow SHALL be constant 0 and clear_flags SHALL be ignored; all other behaviour is identical.

Verification
REQ-036 Bench SHALL cover prefill: reset, then 7 in_ready pulses (values 1..7) plus codec_ready -> sample_out = 0, filling = 1, level = 7; the 8th write -> filling = 0, level = 8.
REQ-037 Bench SHALL cover ordering: after prefill with values 1..8, 8 codec_ready pulses -> sample_out = 1,2,...,8, each 1 cycle after its pulse, level = 0.
REQ-038 Bench SHALL cover overflow: 17 writes without reads -> level = 16, overflow = 1, and subsequent reads return entries 1..16 (the 17th is dropped).
REQ-039 Bench SHALL cover underflow: in RUN at level = 0, a codec_ready -> sample_out holds the last value, underflow = 1, filling = 1; clear_flags -> underflow = 0.
REQ-040 Bench SHALL cover simultaneous events: in RUN at level = 16, in_ready and codec_ready in the same cycle -> level = 16, overflow = 0, oldest entry out; pointers wrap correctly over 40 continuous samples.
REQ-041 Bench SHALL cover mid-stream reset: reset at level = 5 -> next cycle level = 0, sample_out = 0, filling = 1, flags = 0; run with and without CODEC_FIFO_STATUS_EN.
